// File: rtl/sm_trace_buffer.sv
// ---------------------------------------------------------------------------
// sm_trace_buffer
//   Captures one {pc, instr} record per valid retire cycle into a FIFO and
//   drains it as a serialized 32-bit word stream over a valid/ready
//   handshake. This lets a slow UART or host debug link keep up with bursts
//   of retired instructions.
//
//   Optional build macro: SM_TRACE_TIMESTAMP_EN
//     When it is defined, a free-running 32-bit cycle counter is stored with
//     each record. Each record is then sent as 3 words: pc, instr, timestamp.
//     When it is not defined, each record is sent as 2 words: pc, instr.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   enable       capture enable; trace_valid is ignored when low
//   clear        synchronous flush of FIFO, FSM and counters
//   trace_valid  a retired-instruction record is presented this cycle
//   trace_pc     retired PC (word index)
//   trace_instr  retired instruction word
//   out_valid    out_data holds a word
//   out_ready    sink accepts the word when out_valid & out_ready
//   out_data     serialized word
//   out_last     marks the final word of a record
//   level        FIFO occupancy; the record being serialized is not counted
//   overflow     sticky flag; at least one record was dropped
//   ovf_count    saturating count of dropped records
// ---------------------------------------------------------------------------
module sm_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int OVF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   trace_valid,
  input  logic [31:0]            trace_pc,
  input  logic [31:0]            trace_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [OVF_W-1:0]       ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef SM_TRACE_TIMESTAMP_EN
  localparam int EW = 96;
  typedef enum logic [1:0] {IDLE, S_PC, S_INSTR, S_TS} state_t;
`else
  localparam int EW = 64;
  typedef enum logic [1:0] {IDLE, S_PC, S_INSTR} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [EW-1:0]   r_hold;
  logic [EW-1:0]   w_entry;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;
  logic [OVF_W-1:0] r_ovf_count;
  // Set for one cycle after IDLE pops. The FSM enters S_PC only on the
  // following edge. This gives the documented pop-then-present latency.
  logic            r_primed;
  logic            w_pop, w_push, w_drop, w_full, w_level_nz;

`ifdef SM_TRACE_TIMESTAMP_EN
  logic [31:0]     r_ts;
  assign w_entry = {trace_pc, trace_instr, r_ts};
`else
  assign w_entry = {trace_pc, trace_instr};
`endif

  assign w_full     = (r_level == LW'(DEPTH));
  assign w_level_nz = (r_level != '0);
  // A full FIFO still accepts a record when a pop frees a slot on the same edge.
  assign w_push = trace_valid & enable & (~w_full | w_pop) & ~clear;
  assign w_drop = trace_valid & enable & w_full & ~w_pop;

  assign level     = r_level;
  assign overflow  = r_overflow;
  assign ovf_count = r_ovf_count;

  // NOTE: every output and next-state signal gets a default first, so no path through the block infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    case (r_state)
      IDLE: begin
        if (r_primed)        w_state_nxt = S_PC;
        else if (w_level_nz) w_pop       = 1'b1;
      end
      S_PC: begin
        out_valid = 1'b1;
        out_data  = r_hold[EW-1 -: 32];
        if (out_ready) w_state_nxt = S_INSTR;
      end
`ifdef SM_TRACE_TIMESTAMP_EN
      S_INSTR: begin
        out_valid = 1'b1;
        out_data  = r_hold[63:32];
        if (out_ready) w_state_nxt = S_TS;
      end
      S_TS: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = r_hold[31:0];
        if (out_ready) begin
          w_pop       = w_level_nz;
          w_state_nxt = w_level_nz ? S_PC : IDLE;
        end
      end
`else
      S_INSTR: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = r_hold[31:0];
        // Pop the next entry while the last word hands off, so records
        // stream back to back with no idle cycle between them.
        if (out_ready) begin
          w_pop       = w_level_nz;
          w_state_nxt = w_level_nz ? S_PC : IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_primed    <= 1'b0;
      r_hold      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_primed    <= 1'b0;
      r_hold      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_primed <= (r_state == IDLE) && w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_ovf_count != {OVF_W{1'b1}}) r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset. The pointers and level define which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

`ifdef SM_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ts <= '0;
    else if (clear) r_ts <= '0;
    else            r_ts <= r_ts + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sm_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_sm_trace_buffer
//   Scoreboard bench for sm_trace_buffer (DEPTH=8). Expected words are queued
//   when records are driven. They are compared when a handshake is observed
//   mid-cycle. Inputs change 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_sm_trace_buffer;
  localparam int DEPTH = 8;
  localparam int OVF_W = 16;
`ifdef SM_TRACE_TIMESTAMP_EN
  localparam bit INSTR_LAST = 1'b0;
`else
  localparam bit INSTR_LAST = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst, enable, clear, trace_valid, out_ready;
  logic [31:0]       trace_pc, trace_instr, out_data;
  logic              out_valid, out_last, overflow;
  logic [3:0]        level;
  logic [OVF_W-1:0]  ovf_count;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {last, data}

  always #5 clk = ~clk;

  sm_trace_buffer #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .level(level), .overflow(overflow), .ovf_count(ovf_count)
  );

`ifdef SM_TRACE_TIMESTAMP_EN
  // Cycle counter as seen by the design: zero after reset or clear, +1 per edge.
  logic [31:0] tb_ts;
  always @(posedge clk or posedge rst) begin
    if (rst)        tb_ts <= '0;
    else if (clear) tb_ts <= '0;
    else            tb_ts <= tb_ts + 1;
  end
`endif

  task automatic enq_record(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({1'b0, pc});
    exp_q.push_back({INSTR_LAST, instr});
`ifdef SM_TRACE_TIMESTAMP_EN
    exp_q.push_back({1'b1, tb_ts});
`endif
  endtask

  // One clock cycle. Any handshake is scored at the falling edge.
  task automatic tick();
    logic [32:0] exp;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word: got last=%b data=%h, required no word", out_last, out_data);
      end else begin
        exp = exp_q.pop_front();
        if ({out_last, out_data} !== exp) begin
          failures++;
          $display("FAIL word: got last=%b data=%h, required last=%b data=%h",
                   out_last, out_data, exp[32], exp[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input bit accepted);
    trace_valid = 1'b1;
    trace_pc    = pc;
    trace_instr = instr;
    if (accepted) enq_record(pc, instr);
    tick();
    trace_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin tick(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_valid: got out_valid=%b after %0d cycles, required 1", name, out_valid, budget);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain: got %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();   // any duplicated word shows up as an unexpected word
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0; trace_valid = 1'b0;
    trace_pc = '0; trace_instr = '0; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data} !== 34'd0) begin
      failures++;
      $display("FAIL reset outputs: got valid=%b last=%b data=%h, required 0/0/0", out_valid, out_last, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (level !== 4'd0 || overflow !== 1'b0 || ovf_count !== '0) begin
      failures++;
      $display("FAIL reset state: got level=%0d ovf=%b cnt=%0d, required 0/0/0", level, overflow, ovf_count);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push(32'd5, 32'h2402_0001, 1'b1);            // edge N
    checks++;
    if (level !== 4'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single N: got level=%0d valid=%b, required 1/0", level, out_valid);
    end
    tick();                                      // edge N+1: pop
    checks++;
    if (level !== 4'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single N+1: got level=%0d valid=%b, required 0/0", level, out_valid);
    end
    tick();                                      // edge N+2: present
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd5 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL single N+2: got valid=%b data=%h last=%b, required 1/00000005/0", out_valid, out_data, out_last);
    end
    wait_drain(10, "single");
    checks++;
    if (level !== 4'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single end: got level=%0d valid=%b, required 0/0", level, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(32'h100, 32'hDEAD_BEEF, 1'b1);
    wait_valid(10, "bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h100 || out_last !== 1'b0) begin
        failures++;
        $display("FAIL bp hold %0d: got valid=%b data=%h last=%b, required 1/00000100/0", i, out_valid, out_data, out_last);
      end
    end
    out_ready = 1'b1;
    wait_drain(10, "bp");
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp end valid: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'(i), 32'h1000 + 32'(i), i < 9);
    checks++;
    if (overflow !== 1'b1 || ovf_count !== 16'd1 || level !== 4'd8) begin
      failures++;
      $display("FAIL ovf state: got ovf=%b cnt=%0d level=%0d, required 1/1/8", overflow, ovf_count, level);
    end
    out_ready = 1'b1;
    wait_drain(60, "ovf");
    checks++;
    if (level !== 4'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf end: got level=%0d ovf=%b, required 0/1", level, overflow);
    end
  endtask

  task automatic test_full_pop();
    int pushed  = 0;
    int bubbles = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(32'h200 + 32'(i), 32'hA00 + 32'(i), 1'b1);
    checks++;
    if (level !== 4'd8) begin
      failures++;
      $display("FAIL full level: got %0d, required 8", level);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && pushed < 6; cyc++) begin
      // Present a record exactly on the edges where the FIFO is full and pops.
      if (out_valid === 1'b1 && out_last === 1'b1) begin
        trace_valid = 1'b1;
        trace_pc    = 32'h300 + 32'(pushed);
        trace_instr = 32'hB00 + 32'(pushed);
        enq_record(trace_pc, trace_instr);
        pushed++;
      end else begin
        trace_valid = 1'b0;
      end
      if (out_valid !== 1'b1) bubbles++;
      tick();
      checks++;
      if (level !== 4'd8) begin
        failures++;
        $display("FAIL full stream level cyc %0d: got %0d, required 8", cyc, level);
      end
    end
    trace_valid = 1'b0;
    checks++;
    if (pushed != 6 || bubbles != 0 || ovf_count !== 16'd1) begin
      failures++;
      $display("FAIL full stream: got pushed=%0d bubbles=%0d cnt=%0d, required 6/0/1", pushed, bubbles, ovf_count);
    end
    wait_drain(80, "full");
  endtask

  task automatic test_enable_mid_drain();
    out_ready = 1'b1;
    push(32'h400, 32'hC00, 1'b1);
    push(32'h401, 32'hC01, 1'b1);
    enable      = 1'b0;
    trace_valid = 1'b1;
    trace_pc    = 32'hBAD;
    trace_instr = 32'hBAD;
    repeat (8) tick();
    trace_valid = 1'b0;
    enable      = 1'b1;
    wait_drain(20, "enable");
    checks++;
    if (level !== 4'd0 || ovf_count !== 16'd1) begin
      failures++;
      $display("FAIL enable end: got level=%0d cnt=%0d, required 0/1", level, ovf_count);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(i), 32'hD00 + 32'(i), 1'b1);
    out_ready = 1'b1;
    tick();                                      // pc word of the held record
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_last !== INSTR_LAST || out_data !== 32'hD00 || level !== 4'd3) begin
      failures++;
      $display("FAIL clear pre: got valid=%b last=%b data=%h level=%0d, required 1/%b/00000d00/3",
               out_valid, out_last, out_data, level, INSTR_LAST);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || ovf_count !== '0) begin
      failures++;
      $display("FAIL clear post: got valid=%b level=%0d ovf=%b cnt=%0d, required 0/0/0/0",
               out_valid, level, overflow, ovf_count);
    end
    out_ready = 1'b1;
    push(32'h600, 32'hE00, 1'b1);
    wait_drain(20, "clear");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push(32'h700, 32'hF00, 1'b1);
    wait_valid(10, "arst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_last, out_data} !== 34'd0 || level !== 4'd0) begin
      failures++;
      $display("FAIL arst outputs: got valid=%b last=%b data=%h level=%0d, required 0/0/0/0",
               out_valid, out_last, out_data, level);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (7) tick();
    push(32'h800, 32'h1234_5678, 1'b1);
    wait_drain(20, "arst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_enable_mid_drain();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
